// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply tile path: sequencer states,
// default datapath sizes and the tile RAM address width helper.
package mm_pkg;

  localparam int DEFAULT_DW   = 8;
  localparam int DEFAULT_TILE = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_WRITE,
    ST_DONE
  } tile_state_e;

  function automatic int tile_aw(input int tile);
    return $clog2(tile * tile);
  endfunction

endpackage

// File: rtl/tile_idx_counter.sv
// Nested i/j/k index counters for one tile: k walks the dot product, j and i
// walk the output element in row-major order.
module tile_idx_counter #(
  parameter int TILE = 4,
  parameter int CW   = $clog2(TILE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          k_inc,
  input  logic          ij_inc,
  output logic [CW-1:0] i,
  output logic [CW-1:0] j,
  output logic [CW-1:0] k,
  output logic          k_last,
  output logic          j_last,
  output logic          ij_last
);

  localparam logic [CW-1:0] LAST = CW'(TILE - 1);

  logic i_last;

  assign k_last  = (k == LAST);
  assign j_last  = (j == LAST);
  assign i_last  = (i == LAST);
  assign ij_last = i_last && j_last;

  // k saturates at its last value so the final address stays on the bus;
  // moving to the next element always restarts the dot product at k=0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (ij_inc) begin
      k <= '0;
      if (j_last) begin
        j <= '0;
        i <= i_last ? '0 : i + CW'(1);
      end else begin
        j <= j + CW'(1);
      end
    end else if (k_inc && !k_last) begin
      k <= k + CW'(1);
    end
  end

endmodule

// File: rtl/mac_tile_seq.sv
// Sequences an external MAC through one TILE x TILE product C = A*B, reading
// the A/B tile RAMs and writing C elements in row-major order.
module mac_tile_seq
  import mm_pkg::*;
#(
  parameter int TILE = DEFAULT_TILE,
  parameter int DW   = DEFAULT_DW,
  parameter int AW   = tile_aw(TILE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic [DW-1:0] mac_a,
  output logic [DW-1:0] mac_b,
  output logic          mac_enable,
  output logic          reset_acc,
  input  logic [DW-1:0] mac_acc,
  output logic          c_we,
  output logic [AW-1:0] c_addr,
  output logic [DW-1:0] c_data
);

  localparam int CW = $clog2(TILE);

  tile_state_e   state, state_next;
  logic          run_last;
  logic          cnt_clear, k_inc, ij_inc;
  logic [CW-1:0] i, j, k;
  logic          k_last, j_last, ij_last;
  logic [AW-1:0] i_ext, j_ext, k_ext, row_base;

  tile_idx_counter #(
    .TILE (TILE),
    .CW   (CW)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .k_inc   (k_inc),
    .ij_inc  (ij_inc),
    .i       (i),
    .j       (j),
    .k       (k),
    .k_last  (k_last),
    .j_last  (j_last),
    .ij_last (ij_last)
  );

  assign i_ext    = AW'(i);
  assign j_ext    = AW'(j);
  assign k_ext    = AW'(k);
  assign row_base = i_ext * AW'(TILE);

  // k holds at its last value for the final two RUN cycles, so run_last
  // marks the second of them, i.e. the cycle consuming the last operand pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      run_last <= 1'b0;
    end else begin
      state    <= state_next;
      run_last <= (state == ST_RUN) && k_last;
    end
  end

  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    k_inc      = 1'b0;
    ij_inc     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    reset_acc  = 1'b0;
    mac_enable = 1'b0;
    c_we       = 1'b0;
    c_addr     = '0;
    c_data     = '0;
    a_addr     = '0;
    b_addr     = '0;
    mac_a      = '0;
    mac_b      = '0;

    if (state != ST_IDLE) begin
      busy   = 1'b1;
      a_addr = row_base + k_ext;
      b_addr = k_ext * AW'(TILE) + j_ext;
      mac_a  = a_data;
      mac_b  = b_data;
    end

    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_clear  = 1'b1;
          state_next = ST_CLR;
        end
      end
      ST_CLR: begin
        reset_acc  = 1'b1;
        k_inc      = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        mac_enable = 1'b1;
        k_inc      = 1'b1;
        if (run_last) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        c_we       = 1'b1;
        c_addr     = row_base + j_ext;
        c_data     = mac_acc;
        ij_inc     = 1'b1;
        state_next = (j_last && ij_last) ? ST_DONE : ST_CLR;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_tile_seq.sv
// Bench for mac_tile_seq: models the A/B tile RAMs and the MAC, and checks
// every C write against a queue of reference results plus the tile timing.
module tb_mac_tile_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done;
  logic [3:0] a_addr, b_addr, c_addr;
  logic [7:0] a_data, b_data, mac_a, mac_b, mac_acc, c_data;
  logic       mac_enable, reset_acc, c_we;

  logic [7:0] a_mem [16];
  logic [7:0] b_mem [16];
  logic [7:0] acc = 8'd0;

  logic [3:0] exp_addr [$];
  logic [7:0] exp_data [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int c0 = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int last_we_cyc = 0;
  int we_base, done_base;

  mac_tile_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_enable (mac_enable),
    .reset_acc  (reset_acc),
    .mac_acc    (mac_acc),
    .c_we       (c_we),
    .c_addr     (c_addr),
    .c_data     (c_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous tile RAMs and the external 8-bit MAC.
  always @(posedge clk) begin
    a_data <= a_mem[a_addr];
    b_data <= b_mem[b_addr];
    if (reset_acc) acc <= 8'd0;
    else if (mac_enable) acc <= acc + mac_a * mac_b;
  end
  assign mac_acc = acc;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every C write.
  always @(negedge clk) begin
    logic [3:0] ea;
    logic [7:0] ed;
    if (reset_acc && mac_enable) overlap_cnt++;
    if (done) done_cnt++;
    if (c_we) begin
      we_cnt++;
      last_we_cyc = cyc;
      if (exp_addr.size() == 0) begin
        check_output("c_we_spurious", 32'(c_we), 32'd0);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        check_output("c_addr", 32'(c_addr), 32'(ea));
        check_output("c_data", 32'(c_data), 32'(ed));
      end
    end
  end

  task automatic load_mats(input int mode);
    for (int x = 0; x < 16; x++) begin
      case (mode)
        0: begin a_mem[x] = (x / 4 == x % 4) ? 8'd1 : 8'd0; b_mem[x] = 8'(x); end
        1: begin a_mem[x] = 8'h01; b_mem[x] = 8'h01; end
        2: begin a_mem[x] = 8'h0F; b_mem[x] = 8'h11; end
        default: begin a_mem[x] = 8'($urandom_range(0, 255)); b_mem[x] = 8'($urandom_range(0, 255)); end
      endcase
    end
  endtask

  task automatic push_expected();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int s = 0;
        for (int k = 0; k < 4; k++) s += int'(a_mem[i*4+k]) * int'(b_mem[k*4+j]);
        exp_addr.push_back(4'(i*4+j));
        exp_data.push_back(8'(s));
      end
    end
  endtask

  task automatic apply_stimulus(input bit hold);
    @(posedge clk); #1;
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    check_output("busy_cycle0", 32'(busy), 32'd0);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    @(negedge clk);
    check_output("busy_cycle1", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(done), 32'd1);
  endtask

  task automatic run_full_tile(input string tag);
    we_base = we_cnt;
    push_expected();
    apply_stimulus(1'b0);
    wait_done({tag, "_done_seen"});
    check_output({tag, "_done_cycle"}, 32'(cyc - c0), 32'd97);
    check_output({tag, "_last_we_cycle"}, 32'(last_we_cyc - c0), 32'd96);
    check_output({tag, "_we_count"}, 32'(we_cnt - we_base), 32'd16);
    @(negedge clk);
    check_output({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_output({tag, "_busy_after"}, 32'(busy), 32'd0);
    check_output({tag, "_queue_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    load_mats(1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_c_we", 32'(c_we), 32'd0);
    check_output("rst_reset_acc", 32'(reset_acc), 32'd0);
    check_output("rst_mac_enable", 32'(mac_enable), 32'd0);
    check_output("rst_a_addr", 32'(a_addr), 32'd0);

    $display("[TB] identity A, ramp B");
    load_mats(0);
    run_full_tile("ident");

    $display("[TB] all ones");
    load_mats(1);
    run_full_tile("ones");

    $display("[TB] 0x0F x 0x11 wrap");
    load_mats(2);
    run_full_tile("wrap");

    $display("[TB] reset at cycle 40");
    load_mats(1);
    push_expected();
    we_base = we_cnt;
    apply_stimulus(1'b0);
    n = 0;
    while (cyc - c0 < 40 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst_cycle", 32'(cyc - c0), 32'd41);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_c_we", 32'(c_we), 32'd0);
    check_output("midrst_mac_enable", 32'(mac_enable), 32'd0);
    check_output("midrst_a_addr", 32'(a_addr), 32'd0);
    check_output("midrst_writes", 32'(we_cnt - we_base), 32'd6);
    exp_addr.delete();
    exp_data.delete();
    repeat (5) @(negedge clk);
    check_output("midrst_no_more_we", 32'(we_cnt - we_base), 32'd6);
    check_output("midrst_still_idle", 32'(busy), 32'd0);

    $display("[TB] start and reset together");
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_output("rst_beats_start", 32'(busy), 32'd0);

    $display("[TB] fresh random tile");
    load_mats(3);
    run_full_tile("rand");

    $display("[TB] start held high across two tiles");
    load_mats(3);
    push_expected();
    push_expected();
    we_base = we_cnt;
    done_base = done_cnt;
    apply_stimulus(1'b1);
    wait_done("hold_done1_seen");
    check_output("hold_done1_cycle", 32'(cyc - c0), 32'd97);
    @(negedge clk);
    check_output("hold_gap_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check_output("hold_restart", 32'(busy), 32'd1);
    wait_done("hold_done2_seen");
    check_output("hold_done2_cycle", 32'(cyc - c0), 32'd195);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_output("hold_final_idle", 32'(busy), 32'd0);
    check_output("hold_done_count", 32'(done_cnt - done_base), 32'd2);
    check_output("hold_we_count", 32'(we_cnt - we_base), 32'd32);
    check_output("hold_queue_left", 32'(exp_addr.size()), 32'd0);

    check_output("acc_clear_enable_overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_tile_seq.md
# mac_tile_seq

Sequencer that drives a single 8-bit MAC unit to compute one TILE×TILE output tile, C = A·B, from two tile buffers. It sits between the UART-loaded A/B tile RAMs, the MAC datapath and the C result RAM, and is started once per tile by the top-level tiling controller. It clears the accumulator, streams TILE operand pairs into the MAC, and writes back one C element per dot product in row-major order.

## Interface
- TILE, 4: tile dimension N; N ≥ 2.
- DW, 8: operand and accumulator width; must equal the MAC width.
- AW, $clog2(TILE*TILE): tile RAM address width.

- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a tile; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last C write.
- a_addr  out  AW  A buffer read address (i*N+k).
- a_data  in  DW  A buffer read data; synchronous RAM, 1-cycle latency.
- b_addr  out  AW  B buffer read address (k*N+j).
- b_data  in  DW  B buffer read data; 1-cycle latency.
- mac_a, mac_b  out  DW each  MAC operands; pass-through of a_data/b_data.
- mac_enable  out  1  MAC accumulate strobe.
- reset_acc  out  1  MAC accumulator clear.
- mac_acc  in  DW  MAC accumulator value.
- c_we  out  1  C buffer write enable.
- c_addr  out  AW  C write address (i*N+j).
- c_data  out  DW  C write data.

## Operation
- States: IDLE, CLR, RUN, WRITE, DONE.
- IDLE: all outputs 0. start=1 → CLR with i=j=0. start is ignored in any other state.
- CLR (1 cycle): reset_acc=1, mac_enable=0. Issue a_addr/b_addr for k=0; set k←1. → RUN.
- RUN (N cycles, t=0..N-1): mac_enable=1, consuming the data for k=t. Issue the address for k=t+1 while t+1<N; addresses hold otherwise. After cycle t=N-1 → WRITE.
- WRITE (1 cycle): c_we=1, c_addr=i*N+j, c_data=mac_acc. Advance j, and on j wrap advance i. If i=j=N-1 → DONE; else → CLR.
- DONE (1 cycle): done=1. → IDLE.
- Arithmetic: results wrap modulo 2^DW, which is the MAC behaviour; there is no saturation or overflow flag.
- Counters i, j, k are $clog2(TILE) bits wide. Address products are computed at AW width.

## Timing
- Each output element takes N+2 cycles (CLR + N×RUN + WRITE). A tile takes N²·(N+2) cycles from the first CLR.
- With start high in IDLE at cycle 0: CLR at cycle 1, last WRITE at cycle N²(N+2), done at N²(N+2)+1, and IDLE with busy=0 the cycle after. For N=4: last WRITE at cycle 96, done at 97.
- reset_acc and mac_enable are never high in the same cycle.
- Operand data reaches the MAC exactly one cycle after its address, matching RAM latency with no extra pipeline register.
- rst mid-operation: the next cycle is IDLE, with all outputs 0 and counters 0. No further c_we. A partially written C tile is left as-is.
- start and rst high together: rst wins.
- start held high through DONE: a new tile begins only from IDLE, so there is one idle cycle between tiles.

## Structure
- Shared package mm_pkg holds the state enum, the default DW, the default TILE and the AW function. The package is shared with the tiling top and the UART loader.
- One sub-module, tile_idx_counter: nested i/j/k counters with clear, k_inc and ij_inc controls, and wrap flags k_last, j_last and ij_last.
- The MAC stays external; this block only drives its control and operand ports.

## Test plan
- N=4, A = identity, B[r][c] = 4r+c → C equals B; exactly 16 c_we pulses at addresses 0..15 in order.
- A all 0x01, B all 0x01 → every C = 0x04.
- A all 0x0F, B all 0x11 → every C = 0xFC (4·255 mod 256); checks wrap.
- start pulse at cycle 0 → busy rises at cycle 1, last c_we at cycle 96, done high only at cycle 97, busy low at cycle 98.
- rst at cycle 40 of a tile → busy=0 and c_we=0 from cycle 41. A fresh start then yields a correct full tile.
- start re-asserted every cycle while busy → done pulses once per tile and no restart occurs mid-tile.
